// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner select, counter sizing.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    StCpu   = 2'd0,
    StDma   = 2'd1,
    StGuard = 2'd2
  } arbState_t;

  typedef enum logic {
    OwnCpu = 1'b0,
    OwnDma = 1'b1
  } owner_t;

  // Bits needed to hold values 0..maxVal (at least one bit).
  function automatic int unsigned cntWidth(input int unsigned maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module dmem_arbiter_sat_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MAX   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  // Count register: clear, else increment until MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MaxVal)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU (MEM stage) has priority, a DMA/loader port gets
// opportunistic beats when the CPU is idle and a forced burst after STARVE_LIMIT refusals.
// A one-cycle guard after every burst guarantees the CPU makes progress.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BURST_MAX    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [DW/8-1:0] cpu_be,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_valid,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [DW/8-1:0] dma_be,
  input  logic          dma_last,
  output logic          dma_ready,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned SW = cntWidth(STARVE_LIMIT - 1);
  localparam int unsigned BW = cntWidth(BURST_MAX - 1);
  localparam logic [SW-1:0] StarveTop = SW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BeatTop   = BW'(BURST_MAX - 1);

  arbState_t state, nextState;
  owner_t    owner;
  logic      dmaAccept;
  logic      starveInc, starveClr, beatInc, beatClr;
  logic [SW-1:0] starveCnt;
  logic [BW-1:0] beatCnt;

  dmem_arbiter_sat_counter #(
    .WIDTH (SW),
    .MAX   (STARVE_LIMIT - 1)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (starveInc),
    .clr   (starveClr),
    .count (starveCnt)
  );

  dmem_arbiter_sat_counter #(
    .WIDTH (BW),
    .MAX   (BURST_MAX - 1)
  ) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (beatInc),
    .clr   (beatClr),
    .count (beatCnt)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StCpu;
    end else begin
      state <= nextState;
    end
  end

  // Next-state, handshake and counter control.
  always_comb begin
    nextState = state;
    dma_ready = 1'b0;
    cpu_stall = 1'b0;
    starveInc = 1'b0;
    starveClr = 1'b1;  // held at zero unless a refusal in CPU state bumps it
    beatInc   = 1'b0;
    beatClr   = 1'b0;
    unique case (state)
      StCpu: begin
        if (!cpu_req) begin
          dma_ready = dma_valid;
        end
        if (dma_valid && !dma_ready) begin
          if (starveCnt == StarveTop) begin
            nextState = StDma;
          end else begin
            starveInc = 1'b1;
            starveClr = 1'b0;
          end
        end
      end
      StDma: begin
        dma_ready = dma_valid;
        cpu_stall = cpu_req;
        beatInc   = dma_valid;
        // Last beat and burst limit may coincide; either gives the same single exit.
        if (!dma_valid || dma_last || (beatCnt == BeatTop)) begin
          nextState = StGuard;
          beatClr   = 1'b1;
        end
      end
      StGuard: begin
        nextState = StCpu;
      end
      default: begin
        nextState = StCpu;
      end
    endcase
  end

  assign dmaAccept = dma_valid & dma_ready;
  assign owner     = dmaAccept ? OwnDma : OwnCpu;

  // Memory port mux; when nobody is active the CPU fields drive and the write is suppressed.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_be    = cpu_be;
    mem_we    = cpu_req & cpu_we & ~cpu_stall;
    if (owner == OwnDma) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_be    = dma_be;
      mem_we    = dma_we;
    end
  end

  assign cpu_rdata = mem_rdata;

  // DMA read return: capture data on an accepted read beat, present it the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else if (dmaAccept && !dma_we) begin
      dma_rvalid <= 1'b1;
      dma_rdata  <= mem_rdata;
    end else begin
      dma_rvalid <= 1'b0;
    end
  end

endmodule
